// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S operating-config types and frame-length constants
package i2s_pkg;

    typedef enum logic [1:0] {ST, SR, MT, MR} mode_t;
    typedef enum logic {I2S, LJ} standard_t;
    typedef enum logic {f16bits, f32bits} frame_size_t;
    typedef enum logic [1:0] {IDLE, L, R} ws_state_t;

    typedef struct packed {
        mode_t       mode;
        standard_t   standard;
        frame_size_t frame_size;
        logic        stereo;
    } OP_t;

    localparam int FRAME16 = 16;
    localparam int FRAME32 = 32;

endpackage

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S/LJ receive deserializer handing channel-tagged words out over valid/ready
// Optional macro I2S_RX_SIGN_EXT_EN: 16-bit words right-justified and sign-extended.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  OP_t               OP,
    input  ws_state_t         state,
    input  logic              sd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_DONE} fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [DATA_W-1:0] aligned, commit_data;
    logic [CNT_W-1:0]  cnt, cnt_nxt, frame_len;
    logic              len16, len16_nxt;
    logic              ch, ch_nxt;
    ws_state_t         prev_state;
    logic              enabled, start, start_word, commit;

    assign enabled   = (OP.mode == SR) || (OP.mode == MR);
    assign start     = (state != prev_state) && ((state == L) || (state == R));
    assign frame_len = len16 ? CNT_W'(FRAME16) : CNT_W'(FRAME32);
    assign busy      = enabled && ((fsm == S_SKIP) || (fsm == S_SHIFT));

    // The cnt received bits sit in the LSBs; shifting them to the top zero-fills missing LSBs.
    assign aligned = shreg << (CNT_W'(DATA_W) - cnt);

`ifdef I2S_RX_SIGN_EXT_EN
    assign commit_data = len16 ? {{(DATA_W-16){aligned[DATA_W-1]}}, aligned[DATA_W-1 -: 16]}
                               : aligned;
`else
    assign commit_data = aligned;
`endif

    always_comb begin
        fsm_nxt    = fsm;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        len16_nxt  = len16;
        ch_nxt     = ch;
        start_word = 1'b0;
        commit     = 1'b0;

        case (fsm)
            S_IDLE, S_DONE: begin
                if (start)
                    start_word = 1'b1;
                else if (state == IDLE)
                    fsm_nxt = S_IDLE;
            end
            S_SKIP: begin
                if (start)
                    start_word = 1'b1;
                else if (state == IDLE)
                    fsm_nxt = S_IDLE;
                else
                    fsm_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // Full word, channel switch or channel drop all close the current word.
                if (start || (state == IDLE) || (cnt == frame_len)) begin
                    commit = (cnt != '0);
                    if (start)
                        start_word = 1'b1;
                    else if (state == IDLE)
                        fsm_nxt = S_IDLE;
                    else
                        fsm_nxt = S_DONE;
                end else begin
                    shreg_nxt = {shreg[DATA_W-2:0], sd};
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase

        if (start_word) begin
            len16_nxt = (OP.frame_size == f16bits);
            ch_nxt    = OP.stereo && (state == R);
            if (OP.standard == I2S) begin
                fsm_nxt   = S_SKIP;
                shreg_nxt = '0;
                cnt_nxt   = '0;
            end else begin
                fsm_nxt   = S_SHIFT;
                shreg_nxt = DATA_W'(sd);
                cnt_nxt   = CNT_W'(1);
            end
        end

        if (!enabled) begin
            fsm_nxt = S_IDLE;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            len16      <= 1'b0;
            ch         <= 1'b0;
            prev_state <= IDLE;
            out_data   <= '0;
            out_ch     <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            len16      <= len16_nxt;
            ch         <= ch_nxt;
            prev_state <= state;
            // A held word wins over a new one; the new word is lost and flagged.
            if (commit && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (commit) begin
                out_data  <= commit_data;
                out_ch    <= ch;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
Slave/master receive deserializer. It sits directly downstream of the WS channel tracker and consumes its per-channel state (IDLE/L/R). It samples serial data on the bit clock, assembles 16- or 32-bit words MSB-first and hands each completed word, tagged with its channel, to the receive FIFO over a valid/ready handshake.

Parameters:
DATA_W, 32, output word width; must be 32, the largest frame size.
CNT_W, 6, bit-counter width; must hold values 0..32.

Ports:
clk  in  1  bit clock (sck); all logic on rising edge
rst  in  1  synchronous reset, active-high
OP  in  OP_t  operating config; uses mode, standard, frame_size, stereo
state  in  ws_state_t  channel state from the WS tracker: IDLE, L or R
sd  in  1  serial data line
out_data  out  DATA_W  assembled word
out_ch  out  1  channel of out_data: 0 = L, 1 = R
out_valid  out  1  out_data/out_ch hold a word
out_ready  in  1  consumer accepts the word when out_valid && out_ready
overrun  out  1  sticky: a completed word was dropped
busy  out  1  a word is being assembled

Behaviour:
- Reset (rst = 1 at a clock edge): out_data = 0, out_ch = 0, out_valid = 0, overrun = 0, busy = 0. Shift register, bit counter and prev_state are cleared (prev_state = IDLE). Reset takes priority over all other events, including a capture in progress.
- Enabled only when OP.mode is SR or MR. When disabled: the FSM is forced to IDLE, busy = 0, and the output register and handshake keep working so a pending word can still drain.
- Start event: state != prev_state and state is L or R. prev_state is registered every cycle.
- FSM states:
  - IDLE: on a start event, go to SKIP if OP.standard == I2S, otherwise go to SHIFT. In the LJ case, the sd bit sampled in the same cycle is bit 0 (the MSB).
  - SKIP: lasts exactly one cycle. The sampled bit is discarded (I2S one-bit delay). Go to SHIFT.
  - SHIFT: shift sd into the LSB each cycle and increment cnt.
- Frame length N is 16 for f16bits and 32 for f32bits; N is latched at the start event.
- Normal commit: when cnt reaches N, commit the word and go to DONE.
- DONE: ignore sd until the next start event.
- Early commit: a start event while in SHIFT with 0 < cnt < N commits the partial word left-aligned, with missing LSBs zero. The new word then starts in the same cycle. A start event in SKIP, or in SHIFT with cnt == 0, abandons the word without committing it.
- state == IDLE while in SHIFT: commit the partial word as in early commit, then go to IDLE.
- Word alignment: a 16-bit word is placed in out_data[31:16], with [15:0] = 0 (unless the optional feature is enabled).
- Commit latency: the word is visible on out_data with out_valid = 1 on the edge after the last bit is sampled.
- out_ch is the channel captured at the start event. In mono (!OP.stereo), every word is tagged L.
- Handshake:
  - out_valid && out_ready at an edge: the word is consumed.
  - A commit arriving while out_valid && !out_ready: the new word is dropped, the old word is kept and overrun is set to 1. overrun is cleared only by rst.
  - Simultaneous consume and commit: the new word loads and out_valid stays 1.
- busy = 1 in SKIP and SHIFT, 0 otherwise.
- Extra sck cycles beyond N within a channel are ignored, because the FSM sits in DONE.

Optional Feature:
I2S_RX_SIGN_EXT_EN
- Defined: a 16-bit word is right-justified into out_data[15:0] and sign-extended from bit 15. A partial 16-bit word is zero-filled in its missing LSBs first, then sign-extended. 32-bit frames are unaffected.
- Undefined: 16-bit words are left-aligned as stated in Behaviour.

Decomposition:
- The shared package i2s_pkg holds: OP_t, ws_state_t (IDLE/L/R), the mode enum (ST/SR/MT/MR), the standard enum (I2S/LJ), frame_size_t (f16bits/f32bits), and the constants FRAME16 = 16 and FRAME32 = 32.
- The local FSM enum (IDLE/SKIP/SHIFT/DONE) stays inside the module.
- No sub-module is needed; the output register and handshake remain inline.

Test Plan:
- I2S, f32bits, stereo, out_ready = 1; state goes L then R after 32 bits each, sd = 0xA5A5_0F0F then 0x1234_5678 → word 0xA5A5_0F0F with out_ch = 0, then 0x1234_5678 with out_ch = 1; the bit sampled in SKIP is excluded.
- LJ, f16bits, sd = 0xBEEF on L → out_data = 0xBEEF_0000. With I2S_RX_SIGN_EXT_EN defined → 0xFFFF_BEEF.
- Early channel switch after 8 bits of 0xFF on a 32-bit frame → committed word 0xFF00_0000, and the next word begins in the same cycle.
- Hold out_ready = 0 across two commits → first word retained, overrun = 1; raise out_ready → first word consumed, overrun stays 1.
- Assert rst mid-SHIFT at bit 10 → all outputs 0 on the next edge and no commit; a fresh L start then yields a correct full word.
- Mode ST with state toggling → busy stays 0 and out_valid never rises.
